// File: rtl/div_seq6_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t       : controller states (IDLE, RUN, DONE)
//   WIDTH_DEFAULT : default operand/result width
package div_seq6_pkg;

  localparam int WIDTH_DEFAULT = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_seq6_sub_unit.sv
// Ripple-borrow subtractor built from full-adder cells: diff = a - b,
// computed as a + ~b + 1.
//   a, b   : N-bit unsigned operands
//   diff   : N-bit difference
//   borrow : 1 when a < b (carry out of the top cell is 0)
module sub_unit #(
  parameter int N = 7
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic [N:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_cell
    logic b_inv;
    assign b_inv      = ~b[i];
    assign diff[i]    = a[i] ^ b_inv ^ carry[i];
    assign carry[i+1] = (a[i] & b_inv) | (a[i] & carry[i]) | (b_inv & carry[i]);
  end

  assign borrow = ~carry[N];

endmodule

// File: rtl/div_seq6.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : request, sampled only in IDLE; dividend/divisor captured with it
//   busy        : high from start acceptance through the DONE cycle
//   done        : one-cycle pulse, results valid
//   quotient    : result, held until the next accepted start
//   remainder   : result, held until the next accepted start
//   div_by_zero : last operation had divisor 0
module div_seq6
  import div_seq6_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t state, state_next;

  logic [WIDTH:0]   a_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] m_reg;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   a_shift;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH:0]   a_next;
  logic [WIDTH-1:0] q_next;
  logic             last_iter;

  // Shift {A,Q} left by one; the MSB of Q moves into the LSB of A.
  assign a_shift = (a_reg << 1) | {{WIDTH{1'b0}}, q_reg[WIDTH-1]};

  sub_unit #(.N(WIDTH + 1)) u_sub (
    .a      (a_shift),
    .b      ({1'b0, m_reg}),
    .diff   (trial),
    .borrow (borrow)
  );

  // Restore on borrow: keep the shifted A and shift a 0 into Q.
  assign a_next    = borrow ? a_shift : trial;
  assign q_next    = {q_reg[WIDTH-2:0], ~borrow};
  assign last_iter = (count == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (divisor == '0) ? DONE : RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg       <= '0;
      q_reg       <= '0;
      m_reg       <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg       <= '0;
            q_reg       <= dividend;
            m_reg       <= divisor;
            count       <= CW'(WIDTH);
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          a_reg <= a_next;
          q_reg <= q_next;
          count <= count - CW'(1);
          if (last_iter) begin
            quotient  <= q_next;
            remainder <= a_next[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_div_seq6.sv
module tb_div_seq6;

  localparam int W = 6;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int dbz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int   checks = 0;
  int   errors = 0;
  int   done_count = 0;
  exp_t sb[$];

  div_seq6 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      exp_t e;
      done_count++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("quotient", int'(quotient), e.q);
        check("remainder", int'(remainder), e.r);
        check("div_by_zero", int'(div_by_zero), e.dbz);
        check("busy_in_done", int'(busy), 1);
        if (e.b != 0) begin
          check("q*d+r", int'(quotient) * e.b + int'(remainder), e.a);
          check("r_lt_d", int'(remainder) < e.b, 1);
        end
      end
    end
  end

  // Wait for done after E0 (sampled #1 after each edge); returns cycles counted.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 50) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic run_op(input int a, input int b, input int q, input int r, input int dbz);
    exp_t e;
    int   cyc;
    e.a = a; e.b = b; e.q = q; e.r = r; e.dbz = dbz;
    @(negedge clk);
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    wait_done(cyc);
    if (cyc >= 50) check("timeout_done", 0, 1);
    else           check("done_latency", cyc, (b == 0) ? 0 : W);
    @(posedge clk); #1;
    check("done_cleared", int'(done), 0);
    check("busy_cleared", int'(busy), 0);
  endtask

  initial begin
    int cyc;
    int dc0;

    // Asynchronous reset with no clock edge involved.
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_dbz", int'(div_by_zero), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(45, 6, 7, 3, 0);
    run_op(63, 1, 63, 0, 0);
    run_op(5, 9, 0, 5, 0);
    run_op(0, 7, 0, 0, 0);
    run_op(20, 0, 63, 20, 1);
    run_op(12, 4, 3, 0, 0);

    // start held high with 9/2 through RUN and DONE of 45/6: ignored.
    begin
      exp_t e;
      e.a = 45; e.b = 6; e.q = 7; e.r = 3; e.dbz = 0;
      dc0 = done_count;
      @(negedge clk);
      dividend = 6'd45;
      divisor  = 6'd6;
      start    = 1'b1;
      sb.push_back(e);
      @(posedge clk); #1;
      dividend = 6'd9;
      divisor  = 6'd2;
      wait_done(cyc);
      if (cyc >= 50) check("ign_timeout", 0, 1);
      else           check("ign_latency", cyc, W);
      @(posedge clk); #1;
      start = 1'b0;
      check("ign_idle_after_done", int'(busy), 0);
      check("ign_quotient_held", int'(quotient), 7);
      check("ign_remainder_held", int'(remainder), 3);
      repeat (3) @(posedge clk);
      #1;
      check("ign_done_pulses", done_count - dc0, 1);
    end

    // Reset between edges at iteration 3 of 45/6.
    begin
      dc0 = done_count;
      @(negedge clk);
      dividend = 6'd45;
      divisor  = 6'd6;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_done", int'(done), 0);
      check("mid_rst_quotient", int'(quotient), 0);
      check("mid_rst_remainder", int'(remainder), 0);
      check("mid_rst_dbz", int'(div_by_zero), 0);
      repeat (W + 2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("mid_rst_no_done", done_count - dc0, 0);
      run_op(50, 7, 7, 1, 0);
    end

    // Exhaustive sweep.
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        if (b == 0) run_op(a, b, (1 << W) - 1, a, 1);
        else        run_op(a, b, a / b, a % b, 0);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got %0d checks, expected completion", checks);
    $fatal(1, "global timeout");
  end

endmodule
